rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
- In-order retirement side of the rename pipeline.
- The rename stage allocates physical registers. This block records each renamed instruction in program order, tracks completion, and retires instructions from the head one per cycle.
- At retirement it returns the displaced (previous) physical register to the free list through the free list's free_valid/free_phys_reg port.
- It also publishes the committed arch-to-phys mapping for the retirement map.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of two.
- IDX_W, 4, log2(ROB_DEPTH).
- ARCH_W, 5, architectural register index width.
- PHYS_W, 6, physical register index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- disp_valid  input  1  rename stage presents an instruction.
- disp_has_dest  input  1  instruction writes a non-x0 destination.
- disp_dest_arch  input  ARCH_W  destination architectural register.
- disp_new_phys  input  PHYS_W  newly allocated physical register.
- disp_old_phys  input  PHYS_W  prior mapping of disp_dest_arch.
- disp_ready  output  1  ROB can accept (not full).
- disp_rob_idx  output  IDX_W  slot assigned to the current dispatch (equals the tail pointer).
- cmpl_valid  input  1  execution reports completion.
- cmpl_rob_idx  input  IDX_W  completed slot.
- flush  input  1  discard all in-flight entries.
- commit_valid  output  1  an instruction retired (registered).
- commit_arch_reg  output  ARCH_W  retired destination arch reg; 0 if no destination.
- commit_phys_reg  output  PHYS_W  retired new physical register.
- free_valid  output  1  return free_phys_reg to the free list (registered).
- free_phys_reg  output  PHYS_W  old physical register being freed.
- rob_empty  output  1  count == 0.

Behaviour:
- **State:** head and tail pointers (IDX_W bits) and count (IDX_W+1 bits). Each entry holds valid, done, has_dest, dest_arch, new_phys and old_phys.
- **Reset:** head, tail and count are 0; all entry valid/done bits are 0. All outputs are 0 except disp_ready=1 and rob_empty=1.
- **Dispatch:**
  - Accepted when disp_valid && disp_ready, where disp_ready = (count != ROB_DEPTH).
  - disp_ready depends only on count. It never looks ahead to a same-cycle commit, so a full ROB refuses dispatch even if the head retires that cycle.
  - On accept: the entry at tail is written with valid=1, done=0 and the payload fields; tail increments modulo ROB_DEPTH (natural wrap).
  - disp_valid while not ready is ignored. The upstream stage holds the instruction.
- **Completion:**
  - cmpl_valid sets done for entry cmpl_rob_idx if that entry is valid.
  - Completion to an invalid entry is ignored.
  - If completion and dispatch target the same index in the same cycle, dispatch wins (done=0).
- **Commit decision (combinational):** retire = entry[head].valid && entry[head].done && !flush. On retire:
  - clear entry[head].valid;
  - increment head modulo ROB_DEPTH;
  - register outputs at the same edge: commit_valid=1, commit_arch_reg = has_dest ? dest_arch : 0, commit_phys_reg = new_phys;
  - free_valid = has_dest, free_phys_reg = old_phys.
  - When not retiring, commit_valid and free_valid are 0. The data outputs hold their last value.
- **Latency:**
  - Completion sampled at edge N, so done is visible from cycle N+1.
  - If that entry is head, retire happens at edge N+1 and commit/free outputs are high during cycle N+2.
  - Maximum one retire per cycle. Back-to-back done entries retire on consecutive cycles.
- **Count update:** count += accept − retire. A simultaneous accept and retire leaves count unchanged; this is legal at any count below ROB_DEPTH.
- **Flush (priority over dispatch, completion and retire):**
  - At the next edge: head=tail=count=0, all valid/done cleared, commit_valid=free_valid=0.
  - No registers are freed; free-list recovery is owned by the rename recovery path.
- **Reset mid-operation:** identical to flush, plus all outputs are zeroed.
- **rob_empty** is combinational from count.

Decomposition:
- **Shared package** (rename_pkg):
  - ARCH_W, PHYS_W, ROB_DEPTH and IDX_W constants;
  - typedef rob_entry_t {valid, done, has_dest, dest_arch, new_phys, old_phys};
  - typedef rob_idx_t.
- **Sub-module** rob_ptr_ctrl: head, tail and count, with full/empty generation and wrap logic.
- Entry array and commit output registers remain in the top module.

Test Plan:
- **Reset, then single instruction:** dispatch {has_dest=1, dest=3, new=33, old=3} → disp_rob_idx=0. Complete idx 0 at cycle 5 → commit_valid=1, commit_arch_reg=3, commit_phys_reg=33, free_valid=1, free_phys_reg=3 in cycle 7; rob_empty=1 afterwards.
- **Out-of-order completion:** dispatch 3 instructions (idx 0,1,2), complete 2 then 1 then 0 → retires in order 0,1,2 on consecutive cycles, each freeing its own old_phys.
- **Full/wrap:**
  - Dispatch 16 → disp_ready=0, and a 17th disp_valid is ignored.
  - Complete and retire idx 0 → disp_ready=1, and the next dispatch gets disp_rob_idx=0 (wrap) with count=16.
- **Full-with-same-cycle-retire:** dispatch attempt in the cycle head retires while count=16 → dispatch rejected; count=15 next cycle.
- **No destination:** dispatch has_dest=0, complete → commit_valid=1, commit_arch_reg=0, free_valid=0.
- **Flush:** with 5 in flight, 2 done, assert flush → next cycle count=0, rob_empty=1, no free_valid pulse; a later dispatch gets idx 0.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename / retirement pipeline.
package rename_pkg;

    localparam int ROB_DEPTH = 16;  // power of two so pointers wrap naturally
    localparam int IDX_W     = 4;   // log2(ROB_DEPTH)
    localparam int ARCH_W    = 5;
    localparam int PHYS_W    = 6;

    typedef logic [IDX_W-1:0] rob_idx_t;
    typedef logic [IDX_W:0]   rob_cnt_t;  // one extra bit so "full" is representable

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [ARCH_W-1:0] dest_arch;
        logic [PHYS_W-1:0] new_phys;
        logic [PHYS_W-1:0] old_phys;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer, with full/empty flags.
module rob_ptr_ctrl
    import rename_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_flush,
    input  logic     i_push,
    input  logic     i_pop,
    output rob_idx_t o_head,
    output rob_idx_t o_tail,
    output rob_cnt_t o_count,
    output logic     o_full,
    output logic     o_empty
);

    rob_idx_t r_head;
    rob_idx_t r_tail;
    rob_cnt_t r_count;

    // Advance pointers on push/pop; flush and reset both return to an empty ROB.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + rob_idx_t'(1);
            if (i_pop)  r_head <= r_head + rob_idx_t'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + rob_cnt_t'(1);
                2'b01:   r_count <= r_count - rob_cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;
    assign o_full  = (r_count == rob_cnt_t'(ROB_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement: records renamed instructions, tracks completion and
// retires one done instruction per cycle from the head, freeing its old
// physical register and publishing the committed mapping.
//
// Dispatch handshake: an instruction transfers on a rising edge where
// disp_valid && disp_ready. disp_ready depends only on the current count
// (never on a same-cycle retire). While disp_valid is high and disp_ready is
// low the upstream stage must hold the instruction stable.
module rob_commit_unit
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic              disp_has_dest,
    input  logic [ARCH_W-1:0] disp_dest_arch,
    input  logic [PHYS_W-1:0] disp_new_phys,
    input  logic [PHYS_W-1:0] disp_old_phys,
    output logic              disp_ready,
    output logic [IDX_W-1:0]  disp_rob_idx,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_rob_idx,
    input  logic              flush,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_arch_reg,
    output logic [PHYS_W-1:0] commit_phys_reg,
    output logic              free_valid,
    output logic [PHYS_W-1:0] free_phys_reg,
    output logic              rob_empty
);

    rob_entry_t r_rob [ROB_DEPTH];

    rob_idx_t   w_head;
    rob_idx_t   w_tail;
    rob_cnt_t   w_count;
    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_retire;
    rob_entry_t w_head_entry;
    rob_entry_t w_new_entry;

    logic              r_commit_valid;
    logic [ARCH_W-1:0] r_commit_arch_reg;
    logic [PHYS_W-1:0] r_commit_phys_reg;
    logic              r_free_valid;
    logic [PHYS_W-1:0] r_free_phys_reg;

    rob_ptr_ctrl u_ptr (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_push  (w_accept),
        .i_pop   (w_retire),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Accept/retire decisions and the entry image written on dispatch.
    always_comb begin
        w_head_entry          = r_rob[w_head];
        w_accept              = disp_valid && !w_full;
        w_retire              = w_head_entry.valid && w_head_entry.done && !flush;
        w_new_entry           = '0;
        w_new_entry.valid     = 1'b1;
        w_new_entry.done      = 1'b0;
        w_new_entry.has_dest  = disp_has_dest;
        w_new_entry.dest_arch = disp_dest_arch;
        w_new_entry.new_phys  = disp_new_phys;
        w_new_entry.old_phys  = disp_old_phys;
    end

    // Entry array: retire clears head, completion marks done, dispatch (written
    // last) overrides a same-index completion so the new entry starts not-done.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) r_rob[i] <= '0;
        end else begin
            if (w_retire) r_rob[w_head].valid <= 1'b0;
            if (cmpl_valid && r_rob[cmpl_rob_idx].valid) r_rob[cmpl_rob_idx].done <= 1'b1;
            if (w_accept) r_rob[w_tail] <= w_new_entry;
        end
    end

    // Registered commit/free outputs; data fields hold between retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_commit_valid    <= 1'b0;
            r_commit_arch_reg <= '0;
            r_commit_phys_reg <= '0;
            r_free_valid      <= 1'b0;
            r_free_phys_reg   <= '0;
        end else begin
            r_commit_valid <= w_retire;
            r_free_valid   <= w_retire && w_head_entry.has_dest;
            if (w_retire) begin
                r_commit_arch_reg <= w_head_entry.has_dest ? w_head_entry.dest_arch : '0;
                r_commit_phys_reg <= w_head_entry.new_phys;
                r_free_phys_reg   <= w_head_entry.old_phys;
            end
        end
    end

    assign disp_ready      = !w_full;
    assign disp_rob_idx    = w_tail;
    assign rob_empty       = w_empty;
    assign commit_valid    = r_commit_valid;
    assign commit_arch_reg = r_commit_arch_reg;
    assign commit_phys_reg = r_commit_phys_reg;
    assign free_valid      = r_free_valid;
    assign free_phys_reg   = r_free_phys_reg;

endmodule
